// File: rtl/pong_match_ctrl.sv
// Match sequencer for Pong: frame-timed serve/point phases, scoring, rally speed-up.
// Optional PONG_AI_HANDICAP_EN lets the score margin override the AI paddle speed.
module pong_match_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int FAST_HITS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       paddle_hit,
    output logic [2:0] state,
    output logic       paddle_en,
    output logic       ball_en,
    output logic       ball_center,
    output logic       serve_dir,
    output logic       player_speed,
    output logic       ai_speed,
    output logic [3:0] score_player,
    output logic [3:0] score_ai,
    output logic       winner
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [3:0] WIN_L      = 4'(WIN_SCORE);
    localparam logic [3:0] FAST_L     = 4'(FAST_HITS);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

    state_t     cur, nxt;
    logic [7:0] cnt, cnt_nx;
    logic [3:0] rally, rally_nx;
    logic [3:0] sp_nx, sa_nx;
    logic       dir_nx, start_q, fast_nx, ai_nx;

    assign state = cur;

    always_comb begin
        nxt      = cur;
        cnt_nx   = cnt;
        rally_nx = rally;
        sp_nx    = score_player;
        sa_nx    = score_ai;
        dir_nx   = serve_dir;
        case (cur)
            IDLE: if (start_btn) begin
                nxt    = SERVE;
                sp_nx  = 4'd0;
                sa_nx  = 4'd0;
                dir_nx = 1'b0;
            end
            SERVE: if (frame_tick) begin
                if (cnt == SERVE_LAST) nxt = PLAY;
                else cnt_nx = cnt + 8'd1;
            end
            PLAY: begin
                if (paddle_hit && rally != 4'hf) rally_nx = rally + 4'd1;
                if (miss_left || miss_right) nxt = POINT;
                // a simultaneous double miss is a dead point: no score, serve side kept
                if (miss_right && !miss_left) begin
                    if (score_player != WIN_L) sp_nx = score_player + 4'd1;
                    dir_nx = 1'b1;
                end
                if (miss_left && !miss_right) begin
                    if (score_ai != WIN_L) sa_nx = score_ai + 4'd1;
                    dir_nx = 1'b0;
                end
            end
            POINT: if (frame_tick) begin
                if (cnt == POINT_LAST)
                    nxt = (score_player == WIN_L || score_ai == WIN_L) ? OVER : SERVE;
                else cnt_nx = cnt + 8'd1;
            end
            OVER: if (start_btn && !start_q) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // the tick that causes a transition is never counted in the new state
        if (nxt != cur) cnt_nx = 8'd0;
        if (nxt == SERVE && cur != SERVE) rally_nx = 4'd0;
        fast_nx = (rally_nx >= FAST_L);
        ai_nx   = fast_nx;
`ifdef PONG_AI_HANDICAP_EN
        if ({1'b0, sp_nx} >= {1'b0, sa_nx} + 5'd2)      ai_nx = 1'b1;
        else if ({1'b0, sa_nx} >= {1'b0, sp_nx} + 5'd2) ai_nx = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur          <= IDLE;
            cnt          <= 8'd0;
            rally        <= 4'd0;
            score_player <= 4'd0;
            score_ai     <= 4'd0;
            serve_dir    <= 1'b0;
            start_q      <= 1'b0;
            paddle_en    <= 1'b0;
            ball_en      <= 1'b0;
            ball_center  <= 1'b1;
            player_speed <= 1'b0;
            ai_speed     <= 1'b0;
            winner       <= 1'b0;
        end else begin
            cur          <= nxt;
            cnt          <= cnt_nx;
            rally        <= rally_nx;
            score_player <= sp_nx;
            score_ai     <= sa_nx;
            serve_dir    <= dir_nx;
            start_q      <= start_btn;
            paddle_en    <= frame_tick && (cur == SERVE || cur == PLAY);
            ball_en      <= frame_tick && (cur == PLAY);
            ball_center  <= (nxt != PLAY);
            player_speed <= fast_nx;
            ai_speed     <= ai_nx;
            winner       <= (nxt == OVER) && (sa_nx == WIN_L);
        end
    end
endmodule
